// File: rtl/excp_ctrl.sv
// Commit-stage exception/interrupt sequencer: arbitrates, kills, flushes, writes CSRs, redirects fetch.
// Optional performance counters are enabled by defining EXCP_PERF_CNT_EN.
module excp_ctrl #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            c0_valid,
  input  logic [14:0]     c0_excp,
  input  logic [PC_W-1:0] c0_pc,
  input  logic [PC_W-1:0] c0_badv,
  input  logic            c0_ertn,
  input  logic            c1_valid,
  input  logic [14:0]     c1_excp,
  input  logic [PC_W-1:0] c1_pc,
  input  logic [PC_W-1:0] c1_badv,
  input  logic            crmd_ie,
  input  logic [12:0]     ecfg_lie,
  input  logic [12:0]     estat_is,
  input  logic [PC_W-1:0] eentry,
  input  logic [PC_W-1:0] tlbrentry,
  input  logic [PC_W-1:0] era,
  input  logic            flush_ack,
  output logic            c0_kill,
  output logic            c1_kill,
  output logic            flush_req,
  output logic            csr_excp_we,
  output logic [5:0]      excp_ecode,
  output logic [8:0]      excp_esubcode,
  output logic [PC_W-1:0] excp_era,
  output logic            badv_we,
  output logic [PC_W-1:0] excp_badv,
  output logic            ertn_we,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            busy
`ifdef EXCP_PERF_CNT_EN
  ,
  output logic [31:0]     excp_cnt,
  output logic [31:0]     int_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FLUSH, WRITE, REDIRECT} state_t;

  state_t          state, state_nxt;
  logic            int_pend;
  logic            take, sel_int, sel_ertn, sel_lane1;
  logic [15:0]     d0, d1, dsel;
  logic            badv_flag, ertn_q;
  logic [PC_W-1:0] target_q;
`ifdef EXCP_PERF_CNT_EN
  logic            int_q;
`endif

  // Returns {badv_flag, ecode, esubcode} for the highest-index set bit.
  function automatic logic [15:0] excp_decode(input logic [14:0] v);
    logic [15:0] r;
    r = '0;
    priority casez (v)
      15'b1??????????????: r = {1'b1, 6'h08, 9'd0};
      15'b01?????????????: r = {1'b1, 6'h3f, 9'd0};
      15'b001????????????: r = {1'b1, 6'h03, 9'd0};
      15'b0001???????????: r = {1'b1, 6'h07, 9'd0};
      15'b00001??????????: r = {1'b0, 6'h0b, 9'd0};
      15'b000001?????????: r = {1'b0, 6'h0c, 9'd0};
      15'b0000001????????: r = {1'b0, 6'h0d, 9'd0};
      15'b00000001???????: r = {1'b0, 6'h0e, 9'd0};
      15'b000000001??????: r = {1'b0, 6'h0f, 9'd0};
      15'b0000000001?????: r = {1'b1, 6'h09, 9'd0};
      15'b00000000001????: r = {1'b1, 6'h08, 9'd1};
      15'b000000000001???: r = {1'b1, 6'h01, 9'd0};
      15'b0000000000001??: r = {1'b1, 6'h02, 9'd0};
      15'b00000000000001?: r = {1'b1, 6'h04, 9'd0};
      15'b000000000000001: r = {1'b0, 6'h12, 9'd0};
      default:             r = '0;
    endcase
    return r;
  endfunction

  assign int_pend = crmd_ie & (|(estat_is & ecfg_lie));
  assign d0       = excp_decode(c0_excp);
  assign d1       = excp_decode(c1_excp);
  assign dsel     = sel_lane1 ? d1 : d0;

  // Event selection and commit kills; once busy, every valid lane is suppressed.
  always_comb begin
    take      = 1'b0;
    sel_int   = 1'b0;
    sel_ertn  = 1'b0;
    sel_lane1 = 1'b0;
    c0_kill   = 1'b0;
    c1_kill   = 1'b0;
    if (state != IDLE) begin
      c0_kill = c0_valid;
      c1_kill = c1_valid;
    end else if (int_pend && c0_valid) begin
      take    = 1'b1;
      sel_int = 1'b1;
      c0_kill = 1'b1;
      c1_kill = 1'b1;
    end else if (c0_valid && (|c0_excp)) begin
      take    = 1'b1;
      c0_kill = 1'b1;
      c1_kill = 1'b1;
    end else if (c0_valid && c0_ertn) begin
      take     = 1'b1;
      sel_ertn = 1'b1;
      c1_kill  = 1'b1;
    end else if (c1_valid && (|c1_excp)) begin
      take      = 1'b1;
      sel_lane1 = 1'b1;
      c1_kill   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    flush_req      = 1'b0;
    csr_excp_we    = 1'b0;
    ertn_we        = 1'b0;
    badv_we        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    busy           = (state != IDLE);
    unique case (state)
      IDLE:     if (take) state_nxt = FLUSH;
      FLUSH: begin
        flush_req = 1'b1;
        if (flush_ack) state_nxt = WRITE;
      end
      WRITE: begin
        csr_excp_we = ~ertn_q;
        ertn_we     = ertn_q;
        badv_we     = badv_flag;
        state_nxt   = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        state_nxt      = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // ERTN returns to the ERA value seen at selection, not at redirect time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      excp_ecode    <= '0;
      excp_esubcode <= '0;
      excp_era      <= '0;
      excp_badv     <= '0;
      badv_flag     <= 1'b0;
      ertn_q        <= 1'b0;
      target_q      <= '0;
    end else if (take) begin
      excp_era  <= sel_lane1 ? c1_pc : c0_pc;
      excp_badv <= sel_lane1 ? c1_badv : c0_badv;
      ertn_q    <= sel_ertn;
      if (sel_int || sel_ertn) begin
        excp_ecode    <= '0;
        excp_esubcode <= '0;
        badv_flag     <= 1'b0;
      end else begin
        {badv_flag, excp_ecode, excp_esubcode} <= dsel;
      end
      if (sel_ertn)                            target_q <= era;
      else if (!sel_int && dsel[14:9] == 6'h3f) target_q <= tlbrentry;
      else                                     target_q <= eentry;
    end
  end

`ifdef EXCP_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_q    <= 1'b0;
      excp_cnt <= '0;
      int_cnt  <= '0;
    end else begin
      if (take) int_q <= sel_int;
      if (state == WRITE && !ertn_q) begin
        if (int_q) int_cnt  <= int_cnt + 32'd1;
        else       excp_cnt <= excp_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_excp_ctrl.sv
// Self-checking bench for excp_ctrl: directed plan steps plus randomized events vs. a rule-level model.
module tb_excp_ctrl;

  logic        clk, rst;
  logic        c0_valid, c0_ertn, c1_valid, crmd_ie, flush_ack;
  logic [14:0] c0_excp, c1_excp;
  logic [31:0] c0_pc, c0_badv, c1_pc, c1_badv, eentry, tlbrentry, era;
  logic [12:0] ecfg_lie, estat_is;
  logic        c0_kill, c1_kill, flush_req, csr_excp_we, badv_we, ertn_we, redirect_valid, busy;
  logic [5:0]  excp_ecode;
  logic [8:0]  excp_esubcode;
  logic [31:0] excp_era, excp_badv, redirect_pc;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit          taken;
    bit          k0;
    bit          k1;
    bit          ertn;
    bit          bwe;
    logic [5:0]  ec;
    logic [8:0]  es;
    logic [31:0] era_v;
    logic [31:0] bv;
    logic [31:0] tgt;
  } exp_t;

  logic [5:0]  ecode_tab [0:14] = '{6'h12, 6'h04, 6'h02, 6'h01, 6'h08, 6'h09, 6'h0f, 6'h0e,
                                    6'h0d, 6'h0c, 6'h0b, 6'h07, 6'h03, 6'h3f, 6'h08};
  logic [14:0] badv_mask = 15'h783e;

  excp_ctrl #(.PC_W(32)) dut (
    .clk(clk), .rst(rst),
    .c0_valid(c0_valid), .c0_excp(c0_excp), .c0_pc(c0_pc), .c0_badv(c0_badv), .c0_ertn(c0_ertn),
    .c1_valid(c1_valid), .c1_excp(c1_excp), .c1_pc(c1_pc), .c1_badv(c1_badv),
    .crmd_ie(crmd_ie), .ecfg_lie(ecfg_lie), .estat_is(estat_is),
    .eentry(eentry), .tlbrentry(tlbrentry), .era(era), .flush_ack(flush_ack),
    .c0_kill(c0_kill), .c1_kill(c1_kill), .flush_req(flush_req), .csr_excp_we(csr_excp_we),
    .excp_ecode(excp_ecode), .excp_esubcode(excp_esubcode), .excp_era(excp_era),
    .badv_we(badv_we), .excp_badv(excp_badv), .ertn_we(ertn_we),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit v0, input logic [14:0] e0, input logic [31:0] pc0,
                               input logic [31:0] bv0, input bit er0, input bit v1,
                               input logic [14:0] e1, input logic [31:0] pc1, input logic [31:0] bv1,
                               input bit ie, input logic [12:0] lie, input logic [12:0] is);
    c0_valid = v0; c0_excp = e0; c0_pc = pc0; c0_badv = bv0; c0_ertn = er0;
    c1_valid = v1; c1_excp = e1; c1_pc = pc1; c1_badv = bv1;
    crmd_ie = ie; ecfg_lie = lie; estat_is = is;
  endtask

  function automatic int top_bit(input logic [14:0] v);
    for (int i = 14; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  // Reference: the arbitration rules applied directly to the current inputs.
  function automatic exp_t ref_model();
    exp_t e;
    int   hi;
    bit   intp;
    e = '{default: '0};
    intp = crmd_ie && ((estat_is & ecfg_lie) != 13'd0);
    if (c0_valid && intp) begin
      e.taken = 1; e.k0 = 1; e.k1 = 1; e.ec = 6'd0; e.es = 9'd0;
      e.era_v = c0_pc; e.tgt = eentry;
    end else if (c0_valid && c0_excp != 15'd0) begin
      hi = top_bit(c0_excp);
      e.taken = 1; e.k0 = 1; e.k1 = 1; e.ec = ecode_tab[hi]; e.es = (hi == 4) ? 9'd1 : 9'd0;
      e.bwe = badv_mask[hi]; e.bv = c0_badv; e.era_v = c0_pc;
      e.tgt = (hi == 13) ? tlbrentry : eentry;
    end else if (c0_valid && c0_ertn) begin
      e.taken = 1; e.k1 = 1; e.ertn = 1; e.tgt = era;
    end else if (c1_valid && c1_excp != 15'd0) begin
      hi = top_bit(c1_excp);
      e.taken = 1; e.k1 = 1; e.ec = ecode_tab[hi]; e.es = (hi == 4) ? 9'd1 : 9'd0;
      e.bwe = badv_mask[hi]; e.bv = c1_badv; e.era_v = c1_pc;
      e.tgt = (hi == 13) ? tlbrentry : eentry;
    end
    return e;
  endfunction

  // Called shortly after a rising edge with the DUT idle and inputs applied.
  task automatic run_txn(input string name, input int ack_delay);
    exp_t e;
    e = ref_model();
    @(negedge clk);
    checkOutput({name, "_c0_kill"}, 32'(c0_kill), 32'(e.k0));
    checkOutput({name, "_c1_kill"}, 32'(c1_kill), 32'(e.k1));
    checkOutput({name, "_busy_idle"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    if (!e.taken) begin
      checkOutput({name, "_busy_none"}, 32'(busy), 32'd0);
      checkOutput({name, "_flush_none"}, 32'(flush_req), 32'd0);
      return;
    end
    checkOutput({name, "_flush_req"}, 32'(flush_req), 32'd1);
    checkOutput({name, "_busy"}, 32'(busy), 32'd1);
    c0_valid = 1'($urandom); c1_valid = 1'($urandom); c0_excp = 15'($urandom);
    c0_ertn = 1'($urandom); crmd_ie = 1'b1; estat_is = 13'h1fff; ecfg_lie = 13'h1fff;
    era = $urandom; eentry = eentry ^ 32'h0000_1000; tlbrentry = tlbrentry ^ 32'h0000_2000;
    #1;
    checkOutput({name, "_busy_k0"}, 32'(c0_kill), 32'(c0_valid));
    checkOutput({name, "_busy_k1"}, 32'(c1_kill), 32'(c1_valid));
    repeat (ack_delay) begin
      @(posedge clk); #1;
      checkOutput({name, "_flush_hold"}, 32'(flush_req), 32'd1);
      checkOutput({name, "_no_we_early"}, 32'(csr_excp_we | ertn_we), 32'd0);
    end
    flush_ack = 1'b1;
    @(posedge clk); #1;
    flush_ack = 1'b0; c0_valid = 1'b0; c1_valid = 1'b0;
    checkOutput({name, "_csr_we"}, 32'(csr_excp_we), 32'(!e.ertn));
    checkOutput({name, "_ertn_we"}, 32'(ertn_we), 32'(e.ertn));
    checkOutput({name, "_badv_we"}, 32'(badv_we), 32'(e.bwe));
    checkOutput({name, "_flush_off"}, 32'(flush_req), 32'd0);
    if (!e.ertn) begin
      checkOutput({name, "_ecode"}, 32'(excp_ecode), 32'(e.ec));
      checkOutput({name, "_esub"}, 32'(excp_esubcode), 32'(e.es));
      checkOutput({name, "_era"}, excp_era, e.era_v);
    end
    if (e.bwe) checkOutput({name, "_badv"}, excp_badv, e.bv);
    @(posedge clk); #1;
    checkOutput({name, "_redir_v"}, 32'(redirect_valid), 32'd1);
    checkOutput({name, "_redir_pc"}, redirect_pc, e.tgt);
    checkOutput({name, "_pulses_off"}, 32'(csr_excp_we | ertn_we | badv_we), 32'd0);
    if (!e.ertn) checkOutput({name, "_ecode_hold"}, 32'(excp_ecode), 32'(e.ec));
    @(posedge clk); #1;
    checkOutput({name, "_idle"}, 32'(busy), 32'd0);
    checkOutput({name, "_redir_off"}, 32'(redirect_valid), 32'd0);
  endtask

  initial begin
    logic [14:0] e0, e1;
    rst = 1'b1; flush_ack = 1'b0;
    eentry = 32'h1c00_8000; tlbrentry = 32'h1c00_f000; era = 32'h0;
    applyStimulus(0, 15'd0, 32'd0, 32'd0, 0, 0, 15'd0, 32'd0, 32'd0, 0, 13'd0, 13'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_flush", 32'(flush_req), 32'd0);
    checkOutput("rst_ecode", 32'(excp_ecode), 32'd0);
    checkOutput("rst_era", excp_era, 32'd0);
    checkOutput("rst_redir", 32'(redirect_valid), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Plan steps 1..5
    applyStimulus(1, 15'h0400, 32'h1c00_0100, 32'h0, 0, 1, 15'd0, 32'h1c00_0104, 32'h0, 0, 13'd0, 13'd0);
    run_txn("sys", 3);
    applyStimulus(1, 15'h2008, 32'h1c00_0110, 32'hdead_0000, 0, 0, 15'd0, 32'h0, 32'h0, 0, 13'd0, 13'd0);
    run_txn("tlbr", 1);
    applyStimulus(1, 15'd0, 32'h1c00_0120, 32'h0, 0, 1, 15'h0010, 32'h1c00_0124, 32'h0bad_0004, 0, 13'd0, 13'd0);
    run_txn("adem_l1", 0);
    applyStimulus(1, 15'h0200, 32'h1c00_0130, 32'h0, 0, 1, 15'd0, 32'h0, 32'h0, 1, 13'h0800, 13'h0800);
    run_txn("int", 2);
    applyStimulus(1, 15'h0200, 32'h1c00_0140, 32'h0, 0, 1, 15'd0, 32'h0, 32'h0, 0, 13'h0800, 13'h0800);
    run_txn("brk", 1);
    era = 32'h1c00_0200;
    applyStimulus(1, 15'd0, 32'h1c00_0150, 32'h0, 1, 1, 15'h0001, 32'h0, 32'h0, 0, 13'd0, 13'd0);
    run_txn("ertn", 2);
    applyStimulus(0, 15'h4000, 32'h0, 32'h0, 1, 0, 15'h4000, 32'h0, 32'h0, 1, 13'h1fff, 13'h1fff);
    run_txn("none", 0);

    // Plan step 6: reset in the middle of a flush
    applyStimulus(1, 15'h0400, 32'h1c00_0160, 32'h0, 0, 0, 15'd0, 32'h0, 32'h0, 0, 13'd0, 13'd0);
    @(posedge clk); #1;
    c0_valid = 1'b0;
    checkOutput("rstf_flush_before", 32'(flush_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstf_flush", 32'(flush_req), 32'd0);
    checkOutput("rstf_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("rstf_quiet", 32'({csr_excp_we, ertn_we, badv_we, redirect_valid, busy}), 32'd0);
    end

    // Randomized events
    for (int n = 0; n < 60; n++) begin
      e0 = ($urandom_range(0, 1) == 1) ? 15'(1 << $urandom_range(0, 14)) : 15'd0;
      if ($urandom_range(0, 3) == 0) e0 = e0 | 15'($urandom);
      e1 = ($urandom_range(0, 1) == 1) ? 15'(1 << $urandom_range(0, 14)) : 15'd0;
      era = $urandom;
      applyStimulus(1'($urandom_range(0, 3) != 0), e0, $urandom, $urandom, 1'($urandom_range(0, 3) == 0),
                    1'($urandom), e1, $urandom, $urandom, 1'($urandom),
                    13'(1 << $urandom_range(0, 12)), ($urandom_range(0, 2) == 0) ? 13'($urandom) : 13'd0);
      run_txn("rnd", $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
